noc_ni_inject_eject: RTL and testbench

- Synthesizable network interface between a processing element and its mesh router port.
- Injection side: accepts payload + destination from the PE, formats 39-bit flits and buffers them in a FIFO toward the router.
- Ejection side: accepts flits from the router, checks the destination field, and presents the payload to the PE through a one-entry skid register.
- Maintains injected, ejected and misrouted packet counters.

---
 rtl/noc_ni_inject_eject.sv | 171 +++++++++++++++++
 tb/tb_noc_ni_inject_eject.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_ni_inject_eject.sv
// noc_ni_inject_eject
//   Network interface between a processing element (PE) and its mesh router
//   port.
//   Injection: PE payload + destination are formatted into single-flit
//   packets and queued in a FifoDepth-entry FIFO toward the router.
//   Ejection: router flits are checked against this node's address. Matching
//   flits are presented to the PE through a one-entry skid register. All
//   other flits are dropped and counted.
//
// Flit format (39 bits):
//   [38] valid marker (1), [37] tail (1), [36:33] dest, [32] 0, [31:0] payload
//
// Ports:
//   clk, rst                    single clock, asynchronous active-low reset
//   pe_tx_data/dest/valid/ready PE -> NI injection handshake
//   o_data/o_data_valid         NI -> router flit, i_data_ready router accept
//   i_data/i_data_valid         router -> NI flit, o_data_ready NI accept
//   pe_rx_data/valid/ready      NI -> PE ejection handshake
//   tx_count, rx_count          packets delivered to router / PE (wrapping)
//   err_count                   misrouted or invalid flits dropped (saturating)
//
// Optional build macro NOC_NI_TIMESTAMP_EN:
//   Replaces the injected payload with a free-running cycle count and adds
//   output pe_rx_latency, which is the ejection cycle minus the flit
//   timestamp.

module noc_ni_inject_eject #(
  parameter int unsigned address      = 0,
  parameter int unsigned AddressWidth = 4,
  parameter int unsigned FifoDepth    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             pe_tx_data,
  input  logic [AddressWidth-1:0] pe_tx_dest,
  input  logic                    pe_tx_valid,
  output logic                    pe_tx_ready,
  output logic [38:0]             o_data,
  output logic                    o_data_valid,
  input  logic                    i_data_ready,
  input  logic [38:0]             i_data,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [31:0]             pe_rx_data,
  output logic                    pe_rx_valid,
  input  logic                    pe_rx_ready,
  output logic [31:0]             tx_count,
  output logic [31:0]             rx_count,
`ifdef NOC_NI_TIMESTAMP_EN
  output logic [31:0]             pe_rx_latency,
`endif
  output logic [15:0]             err_count
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [AddressWidth-1:0] NodeId   = AddressWidth'(address);
  localparam logic [CntW-1:0]         FullCount = CntW'(FifoDepth);

  // ---------------------------------------------------------------------------
  // Payload source
  // ---------------------------------------------------------------------------
  logic [31:0] tx_payload;

`ifdef NOC_NI_TIMESTAMP_EN
  logic [31:0] cycle_cnt;
  logic        unused_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cycle_cnt <= '0;
    else      cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign tx_payload  = cycle_cnt;
  assign unused_bits = ^{i_data[37], i_data[32], pe_tx_data};
`else
  logic unused_bits;

  assign tx_payload  = pe_tx_data;
  assign unused_bits = ^{i_data[37], i_data[32]};
`endif

  // ---------------------------------------------------------------------------
  // Injection FIFO
  // ---------------------------------------------------------------------------
  logic [38:0]     mem [FifoDepth];
  logic [PtrW-1:0] head;
  logic [PtrW-1:0] tail;
  logic [CntW-1:0] count;
  logic            push;
  logic            pop;

  // Ready uses only the stored occupancy. A full FIFO stays not-ready even
  // when a pop is pending, so the path from the router's ready to the PE's
  // ready is not combinational.
  assign pe_tx_ready  = rst && (count != FullCount);
  assign o_data_valid = (count != '0);
  assign o_data       = mem[head];
  assign push         = pe_tx_valid && pe_tx_ready;
  assign pop          = o_data_valid && i_data_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the storage array is reset on purpose. o_data is read straight
      // from the head entry, so it is defined (zero) out of reset and never
      // shows stale flits from before a reset.
      for (int i = 0; i < int'(FifoDepth); i++) mem[i] <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      tx_count <= '0;
    end else begin
      // NOTE: all state updates use non-blocking assignments, so every
      // process sees the pre-edge value regardless of evaluation order.
      if (push) begin
        mem[tail] <= {2'b11, pe_tx_dest, 1'b0, tx_payload};
        tail      <= tail + PtrW'(1);
      end
      if (pop) begin
        head     <= head + PtrW'(1);
        tx_count <= tx_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Ejection skid register
  // ---------------------------------------------------------------------------
  logic accept;
  logic dest_hit;
  logic rx_xfer;

  assign o_data_ready = rst && (!pe_rx_valid || pe_rx_ready);
  assign accept       = i_data_valid && o_data_ready;
  assign dest_hit     = i_data[38] && (i_data[36:33] == NodeId);
  assign rx_xfer      = pe_rx_valid && pe_rx_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_rx_valid   <= 1'b0;
      pe_rx_data    <= '0;
      rx_count      <= '0;
      err_count     <= '0;
`ifdef NOC_NI_TIMESTAMP_EN
      pe_rx_latency <= '0;
`endif
    end else begin
      // A new matching flit refills the skid in the same cycle that the PE
      // drains it, which sustains one packet per cycle.
      if (accept && dest_hit) begin
        pe_rx_valid   <= 1'b1;
        pe_rx_data    <= i_data[31:0];
`ifdef NOC_NI_TIMESTAMP_EN
        pe_rx_latency <= cycle_cnt - i_data[31:0];
`endif
      end else if (rx_xfer) begin
        pe_rx_valid <= 1'b0;
      end
      if (accept && !dest_hit && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
      if (rx_xfer)
        rx_count <= rx_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_noc_ni_inject_eject.sv
// Testbench for noc_ni_inject_eject (default build, node address 3).
// Directed scenarios plus a randomized run, checked against a queue-based
// behavioural model of the interface.

module tb_noc_ni_inject_eject;

  localparam logic [3:0] NODE  = 4'd3;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pe_tx_data;
  logic [3:0]  pe_tx_dest;
  logic        pe_tx_valid;
  logic        pe_tx_ready;
  logic [38:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic [38:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [31:0] pe_rx_data;
  logic        pe_rx_valid;
  logic        pe_rx_ready;
  logic [31:0] tx_count;
  logic [31:0] rx_count;
  logic [15:0] err_count;

  int checks = 0;
  int passes = 0;

  noc_ni_inject_eject #(.address(3), .AddressWidth(4), .FifoDepth(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pe_tx_data   (pe_tx_data),
    .pe_tx_dest   (pe_tx_dest),
    .pe_tx_valid  (pe_tx_valid),
    .pe_tx_ready  (pe_tx_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .pe_rx_data   (pe_rx_data),
    .pe_rx_valid  (pe_rx_valid),
    .pe_rx_ready  (pe_rx_ready),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: packet queue, skid contents and counters
  // ---------------------------------------------------------------------------
  logic [38:0] m_q[$];
  logic        m_rx_valid;
  logic [31:0] m_rx_data;
  logic [31:0] m_tx_cnt;
  logic [31:0] m_rx_cnt;
  logic [15:0] m_err;
  logic        m_push;
  logic        m_acc;

  task automatic model_reset();
    m_q.delete();
    m_rx_valid = 1'b0;
    m_rx_data  = '0;
    m_tx_cnt   = '0;
    m_rx_cnt   = '0;
    m_err      = '0;
    m_push     = 1'b0;
    m_acc      = 1'b0;
  endtask

  // Advances the model across one clock edge, using the inputs currently
  // driven.
  task automatic model_edge();
    logic        pop;
    logic        xfer;
    logic        hit;
    logic [38:0] tmp;
    m_push = pe_tx_valid && (m_q.size() < DEPTH);
    pop    = (m_q.size() > 0) && i_data_ready;
    xfer   = m_rx_valid && pe_rx_ready;
    m_acc  = i_data_valid && (!m_rx_valid || pe_rx_ready);
    hit    = i_data[38] && (i_data[36:33] == NODE);
    if (pop) begin
      tmp = m_q.pop_front();
      m_tx_cnt = m_tx_cnt + 1;
    end
    if (m_push) m_q.push_back({2'b11, pe_tx_dest, 1'b0, pe_tx_data});
    if (xfer) begin
      m_rx_cnt   = m_rx_cnt + 1;
      m_rx_valid = 1'b0;
    end
    if (m_acc) begin
      if (hit) begin
        m_rx_valid = 1'b1;
        m_rx_data  = i_data[31:0];
      end else if (m_err != 16'hFFFF) begin
        m_err = m_err + 1;
      end
    end
  endtask

  // The clock edge plus model update. Returns at the following negedge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b0; pe_tx_valid = 0; pe_tx_data = '0; pe_tx_dest = '0;
    i_data_ready = 0; i_data = '0; i_data_valid = 0; pe_rx_ready = 0;
    model_reset();
    @(negedge clk); #1;
    checks++; if (o_data_valid !== 1'b0 || pe_rx_valid !== 1'b0) $display("FAIL reset_valids: o_data_valid=%b pe_rx_valid=%b want 0 0", o_data_valid, pe_rx_valid); else passes++;
    checks++; if (o_data !== 39'h0 || pe_rx_data !== 32'h0) $display("FAIL reset_data: o_data=%h pe_rx_data=%h want 0", o_data, pe_rx_data); else passes++;
    checks++; if (tx_count !== 0 || rx_count !== 0 || err_count !== 0) $display("FAIL reset_counters: %0d %0d %0d want 0", tx_count, rx_count, err_count); else passes++;
    checks++; if (pe_tx_ready !== 1'b0 || o_data_ready !== 1'b0) $display("FAIL reset_readys: %b %b want 0 0", pe_tx_ready, o_data_ready); else passes++;
    @(negedge clk);
    rst = 1'b1; #1;
    checks++; if (pe_tx_ready !== 1'b1 || o_data_ready !== 1'b1) $display("FAIL release_readys: %b %b want 1 1", pe_tx_ready, o_data_ready); else passes++;
  endtask

  task automatic test_single_push();
    pe_tx_valid = 1; pe_tx_dest = 4'd5; pe_tx_data = 32'hDEADBEEF; i_data_ready = 1;
    #1;
    checks++; if (pe_tx_ready !== 1'b1) $display("FAIL push_ready: got %b want 1", pe_tx_ready); else passes++;
    tick();
    pe_tx_valid = 0; #1;
    checks++; if (o_data !== 39'h6A_DEADBEEF || o_data_valid !== 1'b1) $display("FAIL push_flit: o_data=%h valid=%b want 6adeadbeef 1", o_data, o_data_valid); else passes++;
    checks++; if (tx_count !== 32'd0) $display("FAIL tx_before_xfer: got %0d want 0", tx_count); else passes++;
    tick(); #1;
    checks++; if (tx_count !== 32'd1 || o_data_valid !== 1'b0) $display("FAIL tx_after_xfer: tx_count=%0d valid=%b want 1 0", tx_count, o_data_valid); else passes++;
  endtask

  task automatic test_fill_drain();
    logic [38:0] exp_flit [DEPTH];
    logic [31:0] base;
    base = m_tx_cnt;
    i_data_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin
      pe_tx_valid = 1; pe_tx_data = $urandom; pe_tx_dest = 4'($urandom);
      exp_flit[i] = {2'b11, pe_tx_dest, 1'b0, pe_tx_data};
      #1;
      checks++; if (pe_tx_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b want 1", i, pe_tx_ready); else passes++;
      tick();
    end
    pe_tx_valid = 0; #1;
    checks++; if (pe_tx_ready !== 1'b0 || o_data_valid !== 1'b1) $display("FAIL full_state: ready=%b valid=%b want 0 1", pe_tx_ready, o_data_valid); else passes++;
    i_data_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      checks++; if (o_data !== exp_flit[i]) $display("FAIL drain_order_%0d: got %h want %h", i, o_data, exp_flit[i]); else passes++;
      checks++; if (pe_tx_ready !== (i != 0)) $display("FAIL drain_ready_%0d: got %b want %b", i, pe_tx_ready, (i != 0)); else passes++;
      tick();
    end
    #1;
    checks++; if (o_data_valid !== 1'b0 || tx_count !== base + 32'd4) $display("FAIL drain_done: valid=%b tx_count=%0d want 0 %0d", o_data_valid, tx_count, base + 32'd4); else passes++;
  endtask

  task automatic test_eject_hit();
    logic [31:0] base;
    base = m_rx_cnt;
    i_data = {2'b11, NODE, 1'b0, 32'h12345678}; i_data_valid = 1; pe_rx_ready = 1;
    #1;
    checks++; if (o_data_ready !== 1'b1) $display("FAIL hit_ready: got %b want 1", o_data_ready); else passes++;
    tick();
    i_data_valid = 0; #1;
    checks++; if (pe_rx_valid !== 1'b1 || pe_rx_data !== 32'h12345678) $display("FAIL hit_data: valid=%b data=%h want 1 12345678", pe_rx_valid, pe_rx_data); else passes++;
    tick(); #1;
    checks++; if (rx_count !== base + 32'd1 || pe_rx_valid !== 1'b0) $display("FAIL hit_count: rx_count=%0d valid=%b want %0d 0", rx_count, pe_rx_valid, base + 32'd1); else passes++;
  endtask

  task automatic test_eject_miss();
    logic [15:0] base;
    base = m_err;
    i_data = {2'b11, 4'd7, 1'b0, 32'hCAFEF00D}; i_data_valid = 1; pe_rx_ready = 1;
    tick();
    i_data_valid = 0; #1;
    checks++; if (pe_rx_valid !== 1'b0 || err_count !== base + 16'd1) $display("FAIL miss_dest: valid=%b err=%0d want 0 %0d", pe_rx_valid, err_count, base + 16'd1); else passes++;
    i_data = {2'b01, NODE, 1'b0, 32'h0BADF00D}; i_data_valid = 1;
    tick();
    i_data_valid = 0; #1;
    checks++; if (pe_rx_valid !== 1'b0 || err_count !== base + 16'd2) $display("FAIL miss_marker: valid=%b err=%0d want 0 %0d", pe_rx_valid, err_count, base + 16'd2); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] base;
    a = $urandom; b = $urandom; base = m_rx_cnt;
    pe_rx_ready = 0;
    i_data = {2'b11, NODE, 1'b0, a}; i_data_valid = 1;
    tick();
    i_data = {2'b11, NODE, 1'b0, b}; #1;
    checks++; if (pe_rx_valid !== 1'b1 || pe_rx_data !== a || o_data_ready !== 1'b0) $display("FAIL skid_full: valid=%b data=%h ready=%b want 1 %h 0", pe_rx_valid, pe_rx_data, o_data_ready, a); else passes++;
    tick(); #1;
    checks++; if (pe_rx_data !== a || o_data_ready !== 1'b0) $display("FAIL skid_hold: data=%h ready=%b want %h 0", pe_rx_data, o_data_ready, a); else passes++;
    pe_rx_ready = 1; #1;
    checks++; if (o_data_ready !== 1'b1) $display("FAIL skid_release: got %b want 1", o_data_ready); else passes++;
    tick();
    i_data_valid = 0; #1;
    checks++; if (pe_rx_valid !== 1'b1 || pe_rx_data !== b || rx_count !== base + 32'd1) $display("FAIL b2b_second: valid=%b data=%h rx=%0d want 1 %h %0d", pe_rx_valid, pe_rx_data, rx_count, b, base + 32'd1); else passes++;
    tick(); #1;
    checks++; if (pe_rx_valid !== 1'b0 || rx_count !== base + 32'd2) $display("FAIL b2b_done: valid=%b rx=%0d want 0 %0d", pe_rx_valid, rx_count, base + 32'd2); else passes++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pe_tx_valid || m_push) begin
        pe_tx_valid = ($urandom_range(0, 3) != 0);
        pe_tx_data  = $urandom;
        pe_tx_dest  = 4'($urandom);
      end
      if (!i_data_valid || m_acc) begin
        i_data_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 9) < 7) i_data = {2'b11, NODE, 1'b0, 32'($urandom)};
        else i_data = {1'($urandom), 1'b1, 4'($urandom), 1'b0, 32'($urandom)};
      end
      i_data_ready = ($urandom_range(0, 2) != 0);
      pe_rx_ready  = ($urandom_range(0, 2) != 0);
      #1;
      checks++;
      if (pe_tx_ready !== (m_q.size() != DEPTH) || o_data_valid !== (m_q.size() != 0)
          || o_data_ready !== (!m_rx_valid || pe_rx_ready) || pe_rx_valid !== m_rx_valid) begin
        $display("FAIL rand_ctrl_%0d: txr=%b odv=%b odr=%b rxv=%b want occupancy %0d skid %b", c,
                 pe_tx_ready, o_data_valid, o_data_ready, pe_rx_valid, m_q.size(), m_rx_valid);
        errs++;
      end else passes++;
      if (m_q.size() != 0) begin
        checks++; if (o_data !== m_q[0]) $display("FAIL rand_flit_%0d: got %h want %h", c, o_data, m_q[0]); else passes++;
      end
      if (m_rx_valid) begin
        checks++; if (pe_rx_data !== m_rx_data) $display("FAIL rand_rx_%0d: got %h want %h", c, pe_rx_data, m_rx_data); else passes++;
      end
      checks++;
      if (tx_count !== m_tx_cnt || rx_count !== m_rx_cnt || err_count !== m_err)
        $display("FAIL rand_cnt_%0d: %0d %0d %0d want %0d %0d %0d", c, tx_count, rx_count, err_count, m_tx_cnt, m_rx_cnt, m_err);
      else passes++;
      tick();
      if (errs > 5) break;
    end
  endtask

  task automatic test_reset_mid();
    pe_tx_valid = 0; i_data_valid = 0; i_data_ready = 1; pe_rx_ready = 1;
    for (int i = 0; i < 6; i++) tick();
    i_data_ready = 0; pe_rx_ready = 0;
    for (int i = 0; i < 3; i++) begin
      pe_tx_valid = 1; pe_tx_data = $urandom; pe_tx_dest = 4'($urandom);
      i_data_valid = (i == 0); i_data = {2'b11, NODE, 1'b0, 32'($urandom)};
      tick();
    end
    pe_tx_valid = 0; i_data_valid = 0; #1;
    checks++; if (o_data_valid !== 1'b1 || pe_rx_valid !== 1'b1 || tx_count !== m_tx_cnt) $display("FAIL pre_reset: odv=%b rxv=%b tx=%0d want 1 1 %0d", o_data_valid, pe_rx_valid, tx_count, m_tx_cnt); else passes++;
    #2 rst = 1'b0; #1;
    model_reset();
    checks++; if (o_data_valid !== 1'b0 || pe_rx_valid !== 1'b0) $display("FAIL async_reset_valids: %b %b want 0 0", o_data_valid, pe_rx_valid); else passes++;
    checks++; if (tx_count !== 0 || rx_count !== 0 || err_count !== 0) $display("FAIL async_reset_counters: %0d %0d %0d want 0", tx_count, rx_count, err_count); else passes++;
    checks++; if (pe_tx_ready !== 1'b0 || o_data_ready !== 1'b0 || o_data !== 39'h0) $display("FAIL async_reset_ports: %b %b %h want 0 0 0", pe_tx_ready, o_data_ready, o_data); else passes++;
    @(negedge clk);
    rst = 1'b1; i_data_ready = 1; pe_rx_ready = 1; #1;
    checks++; if (o_data_valid !== 1'b0 || pe_tx_ready !== 1'b1) $display("FAIL post_reset_empty: odv=%b txr=%b want 0 1", o_data_valid, pe_tx_ready); else passes++;
    tick(); #1;
    checks++; if (o_data_valid !== 1'b0 || tx_count !== 32'd0) $display("FAIL post_reset_idle: odv=%b tx=%0d want 0 0", o_data_valid, tx_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_eject_hit();
    test_eject_miss();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
